// File: rtl/systolic_mac_pe_if.sv
// rtl/systolic_mac_pe_if.sv - operand, weight-chain and result bundle for one systolic MAC PE
//
// Signals (directions as seen from the PE / slave modport):
//   w_in, w_shift, w_swap  in   weight load chain input and shadow/active controls
//   w_out                  out  current shadow weight, to the next PE in the chain
//   d_in, d_valid          in   data operand and its qualifier
//   mode, acc_len          in   operating mode and MAC run length
//   d_out, d_valid_out     out  data forwarded east, one cycle late
//   r, r_valid, ovf        out  result register, update pulse, sticky saturation flag
interface systolic_mac_pe_if #(
   parameter int DATA_W   = 8,
   parameter int WEIGHT_W = 16,
   parameter int ACC_W    = 32,
   parameter int CNT_W    = 8
);
   logic [WEIGHT_W-1:0] w_in;
   logic                w_shift;
   logic                w_swap;
   logic [WEIGHT_W-1:0] w_out;
   logic [DATA_W-1:0]   d_in;
   logic                d_valid;
   logic [1:0]          mode;
   logic [CNT_W-1:0]    acc_len;
   logic [DATA_W-1:0]   d_out;
   logic                d_valid_out;
   logic [ACC_W-1:0]    r;
   logic                r_valid;
   logic                ovf;

   modport master (
      output w_in, w_shift, w_swap, d_in, d_valid, mode, acc_len,
      input  w_out, d_out, d_valid_out, r, r_valid, ovf
   );

   modport slave (
      input  w_in, w_shift, w_swap, d_in, d_valid, mode, acc_len,
      output w_out, d_out, d_valid_out, r, r_valid, ovf
   );
endinterface

// File: rtl/systolic_mac_pe.sv
// rtl/systolic_mac_pe.sv - systolic processing element: broadcast, multiply and saturating MAC
//
// Ports:
//   clk  in   clock, all state on the rising edge
//   rst  in   synchronous active-high reset, overrides every other input
//   pe   slave side of systolic_mac_pe_if (weight chain, data operand,
//        mode/run length, east data forward, result/valid/overflow)
//
// Modes: 00 HOLD, 01 BCAST, 10 MUL, 11 MAC (IDLE/ACC run over acc_len samples).
module systolic_mac_pe #(
   parameter int DATA_W   = 8,
   parameter int WEIGHT_W = 16,
   parameter int ACC_W    = 32,
   parameter bit SIGNED   = 1'b0,
   parameter int CNT_W    = 8
) (
   input logic              clk,
   input logic              rst,
   systolic_mac_pe_if.slave pe
);
   localparam int PROD_W = DATA_W + WEIGHT_W;
   localparam int SUM_W  = ACC_W + 1;

   localparam logic [1:0] MODE_HOLD  = 2'b00;
   localparam logic [1:0] MODE_BCAST = 2'b01;
   localparam logic [1:0] MODE_MUL   = 2'b10;
   localparam logic [1:0] MODE_MAC   = 2'b11;

   typedef enum logic {IDLE, ACC} state_t;

   state_t              state;
   logic [WEIGHT_W-1:0] shadow_w;
   logic [WEIGHT_W-1:0] active_w;
   logic [DATA_W-1:0]   d_out_q;
   logic                d_valid_q;
   logic [ACC_W-1:0]    r_q;
   logic                r_valid_q;
   logic                ovf_q;
   logic [ACC_W-1:0]    acc;
   logic [CNT_W-1:0]    cnt;
   logic [CNT_W-1:0]    len_q;

   logic [ACC_W-1:0]    prod_ext;
   logic [ACC_W-1:0]    d_ext;
   logic [ACC_W-1:0]    sat_sum;
   logic                sat_hit;
   logic [CNT_W-1:0]    len_eff;
   logic [CNT_W:0]      cnt_next;

   // A zero run length behaves as a single-sample run.
   assign len_eff  = (pe.acc_len == '0) ? CNT_W'(1) : pe.acc_len;
   assign cnt_next = {1'b0, cnt} + (CNT_W+1)'(1);

   generate
      if (SIGNED) begin : g_signed
         logic signed [PROD_W-1:0] prod_s;
         logic signed [SUM_W-1:0]  sum_w;

         assign prod_s   = PROD_W'($signed(active_w)) * PROD_W'($signed(pe.d_in));
         assign prod_ext = ACC_W'(prod_s);
         assign d_ext    = ACC_W'($signed(pe.d_in));
         assign sum_w    = SUM_W'($signed(acc)) + SUM_W'($signed(prod_ext));
         // Overflow when the extra sign bit disagrees with the result sign bit;
         // the extra bit tells which rail was crossed.
         assign sat_hit  = sum_w[ACC_W] != sum_w[ACC_W-1];
         assign sat_sum  = !sat_hit      ? sum_w[ACC_W-1:0] :
                           sum_w[ACC_W]  ? {1'b1, {(ACC_W-1){1'b0}}} :
                                           {1'b0, {(ACC_W-1){1'b1}}};
      end else begin : g_unsigned
         logic [PROD_W-1:0] prod_u;
         logic [SUM_W-1:0]  sum_w;

         assign prod_u   = PROD_W'(active_w) * PROD_W'(pe.d_in);
         assign prod_ext = ACC_W'(prod_u);
         assign d_ext    = ACC_W'(pe.d_in);
         assign sum_w    = SUM_W'(acc) + SUM_W'(prod_ext);
         assign sat_hit  = sum_w[ACC_W];
         assign sat_sum  = sat_hit ? {ACC_W{1'b1}} : sum_w[ACC_W-1:0];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         shadow_w  <= '0;
         active_w  <= '0;
         d_out_q   <= '0;
         d_valid_q <= 1'b0;
         r_q       <= '0;
         r_valid_q <= 1'b0;
         ovf_q     <= 1'b0;
         acc       <= '0;
         cnt       <= '0;
         len_q     <= '0;
      end else begin
         d_out_q   <= pe.d_in;
         d_valid_q <= pe.d_valid;

         // Both use the pre-edge shadow value, so shift+swap together move
         // the old shadow into active while the new weight enters shadow.
         if (pe.w_shift) shadow_w <= pe.w_in;
         if (pe.w_swap)  active_w <= shadow_w;

         r_valid_q <= 1'b0;

         // Leaving MAC aborts any open run; the new mode still acts below.
         if (pe.mode != MODE_MAC) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
         end

         case (pe.mode)
            MODE_HOLD: begin
            end
            MODE_BCAST: begin
               if (pe.d_valid) begin
                  r_q       <= d_ext;
                  r_valid_q <= 1'b1;
               end
            end
            MODE_MUL: begin
               if (pe.d_valid) begin
                  r_q       <= prod_ext;
                  r_valid_q <= 1'b1;
               end
            end
            MODE_MAC: begin
               if (pe.d_valid) begin
                  case (state)
                     IDLE: begin
                        if (len_eff == CNT_W'(1)) begin
                           r_q       <= prod_ext;
                           r_valid_q <= 1'b1;
                        end else begin
                           acc   <= prod_ext;
                           cnt   <= CNT_W'(1);
                           len_q <= len_eff;
                           state <= ACC;
                        end
                     end
                     ACC: begin
                        if (sat_hit) ovf_q <= 1'b1;
                        if (cnt_next == {1'b0, len_q}) begin
                           r_q       <= sat_sum;
                           r_valid_q <= 1'b1;
                           acc       <= '0;
                           cnt       <= '0;
                           state     <= IDLE;
                        end else begin
                           acc <= sat_sum;
                           cnt <= cnt_next[CNT_W-1:0];
                        end
                     end
                     default: state <= IDLE;
                  endcase
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign pe.w_out       = shadow_w;
   assign pe.d_out       = d_out_q;
   assign pe.d_valid_out = d_valid_q;
   assign pe.r           = r_q;
   assign pe.r_valid     = r_valid_q;
   assign pe.ovf         = ovf_q;
endmodule

// File: tb/tb_systolic_mac_pe.sv
// tb/tb_systolic_mac_pe.sv - directed bench for systolic_mac_pe in three configurations
module tb_systolic_mac_pe;
   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] w_in;
   logic        w_shift;
   logic        w_swap;
   logic [7:0]  d_in;
   logic        d_valid;
   logic [1:0]  mode;
   logic [7:0]  acc_len;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   systolic_mac_pe_if #(.DATA_W(8), .WEIGHT_W(16), .ACC_W(32), .CNT_W(8)) b0 ();
   systolic_mac_pe_if #(.DATA_W(8), .WEIGHT_W(16), .ACC_W(24), .CNT_W(8)) b1 ();
   systolic_mac_pe_if #(.DATA_W(8), .WEIGHT_W(16), .ACC_W(32), .CNT_W(8)) b2 ();

   assign b0.w_in = w_in;  assign b0.w_shift = w_shift;  assign b0.w_swap = w_swap;
   assign b0.d_in = d_in;  assign b0.d_valid = d_valid;  assign b0.mode = mode;
   assign b0.acc_len = acc_len;
   assign b1.w_in = w_in;  assign b1.w_shift = w_shift;  assign b1.w_swap = w_swap;
   assign b1.d_in = d_in;  assign b1.d_valid = d_valid;  assign b1.mode = mode;
   assign b1.acc_len = acc_len;
   assign b2.w_in = w_in;  assign b2.w_shift = w_shift;  assign b2.w_swap = w_swap;
   assign b2.d_in = d_in;  assign b2.d_valid = d_valid;  assign b2.mode = mode;
   assign b2.acc_len = acc_len;

   systolic_mac_pe #(.DATA_W(8), .WEIGHT_W(16), .ACC_W(32), .SIGNED(1'b0), .CNT_W(8))
      u0 (.clk(clk), .rst(rst), .pe(b0));
   systolic_mac_pe #(.DATA_W(8), .WEIGHT_W(16), .ACC_W(24), .SIGNED(1'b0), .CNT_W(8))
      u1 (.clk(clk), .rst(rst), .pe(b1));
   systolic_mac_pe #(.DATA_W(8), .WEIGHT_W(16), .ACC_W(32), .SIGNED(1'b1), .CNT_W(8))
      u2 (.clk(clk), .rst(rst), .pe(b2));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      w_in = '0; w_shift = 0; w_swap = 0; d_in = '0; d_valid = 0;
      mode = 2'b00; acc_len = '0;
      rst = 1;
      step();
      rst = 0;
   endtask

   task automatic load_weight(input logic [15:0] w);
      w_in = w; w_shift = 1;
      step();
      w_shift = 0; w_swap = 1;
      step();
      w_swap = 0;
   endtask

   task automatic test_reset();
      do_reset();
      tests++;
      if ({b0.r, b0.r_valid, b0.ovf, b0.w_out, b0.d_out, b0.d_valid_out} !== '0) begin
         fails++;
         $display("FAIL reset_init: r=%0h rv=%0b ovf=%0b w_out=%0h d_out=%0h dvo=%0b want all 0",
                  b0.r, b0.r_valid, b0.ovf, b0.w_out, b0.d_out, b0.d_valid_out);
      end
      load_weight(16'd2);
      mode = 2'b11; acc_len = 8'd4;
      d_in = 8'd7; d_valid = 1; step();
      step();
      rst = 1; d_in = 8'd9; step();
      rst = 0;
      tests++;
      if ({b0.r, b0.r_valid, b0.ovf, b0.w_out, b0.d_out, b0.d_valid_out} !== '0) begin
         fails++;
         $display("FAIL reset_mid_run: r=%0h rv=%0b ovf=%0b w_out=%0h d_out=%0h dvo=%0b want all 0",
                  b0.r, b0.r_valid, b0.ovf, b0.w_out, b0.d_out, b0.d_valid_out);
      end
      d_valid = 0;
      load_weight(16'd3);
      for (int i = 1; i <= 4; i++) begin
         d_in = 8'(i); d_valid = 1;
         step();
      end
      d_valid = 0;
      tests++;
      if (b0.r !== 32'd30 || b0.r_valid !== 1'b1) begin
         fails++;
         $display("FAIL reset_fresh_run: r=%0d rv=%0b want r=30 rv=1", b0.r, b0.r_valid);
      end
   endtask

   task automatic test_load_chain();
      do_reset();
      w_in = 16'd3; w_shift = 1; step();
      w_shift = 0;
      tests++;
      if (b0.w_out !== 16'd3) begin
         fails++;
         $display("FAIL chain_w_out: got %0h want 3", b0.w_out);
      end
      w_swap = 1; step();
      w_swap = 0;
      mode = 2'b10; d_in = 8'd5; d_valid = 1; step();
      d_valid = 0;
      tests++;
      if (b0.r !== 32'd15 || b0.r_valid !== 1'b1) begin
         fails++;
         $display("FAIL chain_mul: r=%0d rv=%0b want r=15 rv=1", b0.r, b0.r_valid);
      end
      tests++;
      if (b0.d_out !== 8'd5 || b0.d_valid_out !== 1'b1) begin
         fails++;
         $display("FAIL chain_forward: d_out=%0d dvo=%0b want 5/1", b0.d_out, b0.d_valid_out);
      end
      step();
      tests++;
      if (b0.r !== 32'd15 || b0.r_valid !== 1'b0 || b0.d_valid_out !== 1'b0) begin
         fails++;
         $display("FAIL chain_hold: r=%0d rv=%0b dvo=%0b want 15/0/0", b0.r, b0.r_valid, b0.d_valid_out);
      end
   endtask

   task automatic test_mac();
      logic [7:0] dv [5] = '{8'd1, 8'd2, 8'd0, 8'd3, 8'd4};
      logic       vv [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
      do_reset();
      load_weight(16'd2);
      mode = 2'b11; acc_len = 8'd4;
      for (int i = 0; i < 5; i++) begin
         d_in = dv[i]; d_valid = vv[i];
         step();
         tests++;
         if (i < 4 && b0.r_valid !== 1'b0) begin
            fails++;
            $display("FAIL mac_early_valid: step %0d rv=%0b want 0", i, b0.r_valid);
         end else if (i == 4 && (b0.r !== 32'd20 || b0.r_valid !== 1'b1)) begin
            fails++;
            $display("FAIL mac_result: r=%0d rv=%0b want r=20 rv=1", b0.r, b0.r_valid);
         end
      end
      d_valid = 0; step();
      tests++;
      if (b0.r_valid !== 1'b0 || b0.ovf !== 1'b0 || b0.r !== 32'd20) begin
         fails++;
         $display("FAIL mac_after: r=%0d rv=%0b ovf=%0b want 20/0/0", b0.r, b0.r_valid, b0.ovf);
      end
   endtask

   task automatic test_swap_timing();
      do_reset();
      load_weight(16'd2);
      w_in = 16'd5; w_shift = 1; step();
      w_shift = 0;
      mode = 2'b11; acc_len = 8'd3; d_in = 8'd1; d_valid = 1;
      step();
      w_swap = 1; step();
      w_swap = 0; step();
      d_valid = 0;
      tests++;
      if (b0.r !== 32'd9 || b0.r_valid !== 1'b1) begin
         fails++;
         $display("FAIL swap_timing: r=%0d rv=%0b want r=9 rv=1", b0.r, b0.r_valid);
      end
   endtask

   task automatic test_saturation();
      do_reset();
      load_weight(16'hFFFF);
      mode = 2'b11; acc_len = 8'd2; d_in = 8'hFF; d_valid = 1;
      step();
      tests++;
      if (b1.r_valid !== 1'b0 || b1.ovf !== 1'b0) begin
         fails++;
         $display("FAIL sat_first: rv=%0b ovf=%0b want 0/0", b1.r_valid, b1.ovf);
      end
      step();
      tests++;
      if (b1.r !== 24'hFFFFFF || b1.ovf !== 1'b1 || b1.r_valid !== 1'b1) begin
         fails++;
         $display("FAIL sat_clamp: r=%0h ovf=%0b rv=%0b want ffffff/1/1", b1.r, b1.ovf, b1.r_valid);
      end
      tests++;
      if (b0.r !== 32'h01FDFE02 || b0.ovf !== 1'b0) begin
         fails++;
         $display("FAIL sat_wide_no_clamp: r=%0h ovf=%0b want 1fdfe02/0", b0.r, b0.ovf);
      end
      mode = 2'b01; d_in = 8'd7; step();
      d_valid = 0;
      tests++;
      if (b1.r !== 24'd7 || b1.ovf !== 1'b1 || b1.r_valid !== 1'b1) begin
         fails++;
         $display("FAIL sat_sticky_bcast: r=%0h ovf=%0b rv=%0b want 7/1/1", b1.r, b1.ovf, b1.r_valid);
      end
   endtask

   task automatic test_signed();
      do_reset();
      load_weight(16'hFFFD);
      mode = 2'b10; d_in = 8'd5; d_valid = 1; step();
      tests++;
      if (b2.r !== 32'hFFFFFFF1 || b2.r_valid !== 1'b1) begin
         fails++;
         $display("FAIL signed_mul: r=%0h rv=%0b want fffffff1/1", b2.r, b2.r_valid);
      end
      tests++;
      if (b0.r !== 32'h0004FFF1) begin
         fails++;
         $display("FAIL unsigned_mul_ref: r=%0h want 4fff1", b0.r);
      end
      mode = 2'b11; acc_len = 8'd4; step(); step();
      mode = 2'b00; step();
      tests++;
      if (b2.r_valid !== 1'b0 || b2.r !== 32'hFFFFFFF1) begin
         fails++;
         $display("FAIL signed_abort: r=%0h rv=%0b want fffffff1/0", b2.r, b2.r_valid);
      end
      mode = 2'b11; acc_len = 8'd2; step(); step();
      d_valid = 0;
      tests++;
      if (b2.r !== 32'hFFFFFFE2 || b2.r_valid !== 1'b1 || b2.ovf !== 1'b0) begin
         fails++;
         $display("FAIL signed_after_abort: r=%0h rv=%0b ovf=%0b want ffffffe2/1/0", b2.r, b2.r_valid, b2.ovf);
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      load_weight(16'd2);
      mode = 2'b11; acc_len = 8'd0; d_in = 8'd3; d_valid = 1; step();
      tests++;
      if (b0.r !== 32'd6 || b0.r_valid !== 1'b1) begin
         fails++;
         $display("FAIL b2b_first: r=%0d rv=%0b want 6/1", b0.r, b0.r_valid);
      end
      d_in = 8'd4; step();
      tests++;
      if (b0.r !== 32'd8 || b0.r_valid !== 1'b1) begin
         fails++;
         $display("FAIL b2b_second: r=%0d rv=%0b want 8/1", b0.r, b0.r_valid);
      end
      d_valid = 0; step();
      tests++;
      if (b0.r !== 32'd8 || b0.r_valid !== 1'b0) begin
         fails++;
         $display("FAIL b2b_idle: r=%0d rv=%0b want 8/0", b0.r, b0.r_valid);
      end
      acc_len = 8'd2; d_in = 8'd1; d_valid = 1; step();
      acc_len = 8'd3; step();
      d_valid = 0;
      tests++;
      if (b0.r !== 32'd4 || b0.r_valid !== 1'b1) begin
         fails++;
         $display("FAIL len_sampled_at_start: r=%0d rv=%0b want 4/1", b0.r, b0.r_valid);
      end
   endtask

   initial begin
      test_reset();
      test_load_chain();
      test_mac();
      test_swap_timing();
      test_saturation();
      test_signed();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
